// File: rtl/chip_test_pkg.sv
// Shared definitions for the flip-flop chip tester.
// Contents:
//   state_t      tester FSM states
//   VB_*         bit positions inside the 5-bit stimulus vector
//   MODE_*       part family selector values
//   INIT_PINS    per-channel pin pattern held while the part is cleared
//   vec_to_pins  maps a stimulus vector onto one channel's {CLR_n,J/D,K,CLK,PRE_n} pins
package chip_test_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        DRIVE  = 3'd2,
        SETTLE = 3'd3,
        SAMPLE = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int VB_CLK = 0;
    localparam int VB_J   = 1;
    localparam int VB_K   = 2;
    localparam int VB_PRE = 3;
    localparam int VB_CLR = 4;

    localparam int MODE_JK = 0;
    localparam int MODE_D  = 1;

    // CLR_n=0 (clear asserted), J/D=0, K=0, CLK=0, PRE_n=1
    localparam logic [4:0] INIT_PINS = 5'b00001;

    // Vector bits 3/4 are "assert" flags; the pins are active-low. The D part has no K pin.
    function automatic logic [4:0] vec_to_pins(input logic [4:0] vec, input logic d_mode);
        return {~vec[VB_CLR], vec[VB_J], (d_mode ? 1'b0 : vec[VB_K]), vec[VB_CLK], ~vec[VB_PRE]};
    endfunction

endpackage

// File: rtl/ff_golden_model.sv
// Golden model of one flip-flop channel, stepped once per applied vector.
// Ports:
//   Clk, Reset  clock, synchronous active-high reset (also used to clear between runs)
//   load        evaluate vec and update q/qn on this edge
//   mode        0 = JK-bar (74109), 1 = D (7474, J bit carries D)
//   vec         stimulus vector (bit0 CLK, bit1 J/D, bit2 K, bit3 preset, bit4 clear)
//   prev_clk    CLK bit of the previously applied vector
//   q, qn       expected outputs
module ff_golden_model
    import chip_test_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       load,
    input  logic       mode,
    input  logic [4:0] vec,
    input  logic       prev_clk,
    output logic       q,
    output logic       qn
);

    logic q_n;
    logic qn_n;
    logic rise_s;

    // Next model state from asynchronous controls first, then the clock edge.
    always_comb begin
        rise_s = ~prev_clk & vec[VB_CLK];
        q_n    = q;
        qn_n   = qn;
        if (vec[VB_CLR] && vec[VB_PRE]) begin
            // both asynchronous inputs asserted: both outputs high
            q_n  = 1'b1;
            qn_n = 1'b1;
        end else if (vec[VB_CLR]) begin
            q_n  = 1'b0;
            qn_n = 1'b1;
        end else if (vec[VB_PRE]) begin
            q_n  = 1'b1;
            qn_n = 1'b0;
        end else begin
            if (rise_s) begin
                if (mode) begin
                    q_n = vec[VB_J];
                end else begin
                    // J and K-bar: 00 reset, 01 hold, 10 toggle, 11 set
                    case ({vec[VB_J], vec[VB_K]})
                        2'b00:   q_n = 1'b0;
                        2'b01:   q_n = q;
                        2'b10:   q_n = ~q;
                        2'b11:   q_n = 1'b1;
                        default: q_n = q;
                    endcase
                end
            end else begin
                q_n = q;
            end
            qn_n = ~q_n;
        end
    end

    // Model state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            q  <= 1'b0;
            qn <= 1'b1;
        end else if (load) begin
            q  <= q_n;
            qn <= qn_n;
        end else begin
            q  <= q;
            qn <= qn;
        end
    end

endmodule

// File: rtl/chip_ff_tester.sv
// Exhaustive tester for dual/quad flip-flop TTL parts (74109 JK-bar, 7474 D).
// Sweeps a 5-bit vector 0..LAST_VEC, drives every channel identically, waits a settle
// window, and compares the synchronised Q/QN of each channel against a golden model.
// Ports:
//   Clk, Reset   clock, synchronous active-high reset
//   Run          start request, honoured in IDLE only
//   DISP_RSLT    result acknowledge, honoured in DONE only
//   dut_drive    per channel c, [5c+4:5c] = {CLR_n,J/D,K,CLK,PRE_n}
//   dut_sense    per channel c, [2c+1:2c] = {QN,Q}, asynchronous
//   vec_o        current vector
//   Done         high in DONE
//   RSLT         1 when every compare matched
//   fail_count   saturating count of mismatching (vector, channel) compares
//   fail_mask    sticky per-channel fail flags
// Optional (macro CHIP_FF_FAIL_CAPTURE_EN): first_fail_vec, first_fail_ch, first_fail_valid
//   record the first mismatch of a run, lowest channel winning a tie.
module chip_ff_tester
    import chip_test_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int MODE       = 0,
    parameter int SETTLE_CYC = 3,
    parameter int LAST_VEC   = 23,
    parameter int CNT_W      = 8
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Run,
    input  logic                DISP_RSLT,
    output logic [NUM_CH*5-1:0] dut_drive,
    input  logic [NUM_CH*2-1:0] dut_sense,
    output logic [4:0]          vec_o,
    output logic                Done,
    output logic                RSLT,
    output logic [CNT_W-1:0]    fail_count,
    output logic [NUM_CH-1:0]   fail_mask
`ifdef CHIP_FF_FAIL_CAPTURE_EN
    ,
    output logic [4:0]          first_fail_vec,
    output logic [1:0]          first_fail_ch,
    output logic                first_fail_valid
`endif
);

    localparam logic             MODE_BIT   = (MODE == MODE_D) ? 1'b1 : 1'b0;
    localparam logic [3:0]       INIT_END   = 4'(SETTLE_CYC - 1);
    localparam logic [3:0]       SETTLE_END = 4'(SETTLE_CYC - 2);
    localparam logic [4:0]       LAST       = 5'(LAST_VEC);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t                state_r;
    state_t                state_n;
    logic [3:0]            cyc_r;
    logic [3:0]            cyc_n;
    logic [4:0]            vec_n;
    logic                  prev_clk_r;
    logic                  prev_clk_n;
    logic [NUM_CH*2-1:0]   sync1_r;
    logic [NUM_CH*2-1:0]   sync2_r;
    logic [NUM_CH-1:0]     mod_q_s;
    logic [NUM_CH-1:0]     mod_qn_s;
    logic [NUM_CH-1:0]     mis_s;
    logic                  model_rst_s;
    logic                  load_s;
    logic [NUM_CH*5-1:0]   drive_n;
    logic                  done_n;
    logic                  rslt_n;
    logic [CNT_W-1:0]      count_n;
    logic [NUM_CH-1:0]     mask_n;
`ifdef CHIP_FF_FAIL_CAPTURE_EN
    logic [4:0]            ffv_n;
    logic [1:0]            ffc_n;
    logic                  ffvalid_n;
`endif

    // The model is cleared in INIT so it matches the part that INIT is clearing.
    assign model_rst_s = Reset | (state_r == INIT);
    assign load_s      = (state_r == DRIVE);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_model
        ff_golden_model u_model (
            .Clk      (Clk),
            .Reset    (model_rst_s),
            .load     (load_s),
            .mode     (MODE_BIT),
            .vec      (vec_o),
            .prev_clk (prev_clk_r),
            .q        (mod_q_s[c]),
            .qn       (mod_qn_s[c])
        );
    end

    // Two-flop synchroniser on the asynchronous part outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1_r <= {(NUM_CH*2){1'b0}};
            sync2_r <= {(NUM_CH*2){1'b0}};
        end else begin
            sync1_r <= dut_sense;
            sync2_r <= sync1_r;
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r    <= IDLE;
            cyc_r      <= 4'd0;
            vec_o      <= 5'd0;
            prev_clk_r <= 1'b0;
            dut_drive  <= {(NUM_CH*5){1'b0}};
            Done       <= 1'b0;
            RSLT       <= 1'b0;
            fail_count <= {CNT_W{1'b0}};
            fail_mask  <= {NUM_CH{1'b0}};
`ifdef CHIP_FF_FAIL_CAPTURE_EN
            first_fail_vec   <= 5'd0;
            first_fail_ch    <= 2'd0;
            first_fail_valid <= 1'b0;
`endif
        end else begin
            state_r    <= state_n;
            cyc_r      <= cyc_n;
            vec_o      <= vec_n;
            prev_clk_r <= prev_clk_n;
            dut_drive  <= drive_n;
            Done       <= done_n;
            RSLT       <= rslt_n;
            fail_count <= count_n;
            fail_mask  <= mask_n;
`ifdef CHIP_FF_FAIL_CAPTURE_EN
            first_fail_vec   <= ffv_n;
            first_fail_ch    <= ffc_n;
            first_fail_valid <= ffvalid_n;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (Run) state_n = INIT; else state_n = IDLE;
            INIT:    if (cyc_r == INIT_END) state_n = DRIVE; else state_n = INIT;
            DRIVE:   state_n = SETTLE;
            SETTLE:  if (cyc_r == SETTLE_END) state_n = SAMPLE; else state_n = SETTLE;
            SAMPLE:  if (vec_o == LAST) state_n = DONE; else state_n = DRIVE;
            DONE:    if (DISP_RSLT) state_n = IDLE; else state_n = DONE;
            default: state_n = IDLE;
        endcase
    end

    // Per-channel compare of synchronised part outputs against the model.
    always_comb begin
        mis_s = {NUM_CH{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            mis_s[c] = (sync2_r[2*c] != mod_q_s[c]) || (sync2_r[2*c+1] != mod_qn_s[c]);
        end
    end

    // Output logic: next values of every registered output.
    always_comb begin
        // cycle counter restarts on every state change
        if (state_n == state_r) cyc_n = cyc_r + 4'd1; else cyc_n = 4'd0;
        vec_n      = vec_o;
        prev_clk_n = prev_clk_r;
        done_n     = (state_n == DONE);
        rslt_n     = RSLT;
        count_n    = fail_count;
        mask_n     = fail_mask;
`ifdef CHIP_FF_FAIL_CAPTURE_EN
        ffv_n     = first_fail_vec;
        ffc_n     = first_fail_ch;
        ffvalid_n = first_fail_valid;
`endif
        case (state_r)
            INIT: begin
                rslt_n     = 1'b1;
                count_n    = {CNT_W{1'b0}};
                mask_n     = {NUM_CH{1'b0}};
                vec_n      = 5'd0;
                prev_clk_n = 1'b0;
`ifdef CHIP_FF_FAIL_CAPTURE_EN
                ffv_n     = 5'd0;
                ffc_n     = 2'd0;
                ffvalid_n = 1'b0;
`endif
            end
            DRIVE: prev_clk_n = vec_o[VB_CLK];
            SAMPLE: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    if (mis_s[c]) begin
                        rslt_n    = 1'b0;
                        mask_n[c] = 1'b1;
                        if (count_n != CNT_MAX) count_n = count_n + CNT_ONE;
                        else count_n = count_n;
                    end else begin
                        mask_n[c] = mask_n[c];
                    end
                end
`ifdef CHIP_FF_FAIL_CAPTURE_EN
                if (!first_fail_valid && (mis_s != {NUM_CH{1'b0}})) begin
                    ffvalid_n = 1'b1;
                    ffv_n     = vec_o;
                    // scan downwards so the lowest failing channel is the one kept
                    for (int c = NUM_CH - 1; c >= 0; c--) begin
                        if (mis_s[c]) ffc_n = 2'(c); else ffc_n = ffc_n;
                    end
                end else begin
                    ffvalid_n = first_fail_valid;
                end
`endif
                if (state_n == DRIVE) vec_n = vec_o + 5'd1; else vec_n = vec_o;
            end
            default: vec_n = vec_o;
        endcase
        // pins follow the state being entered; DRIVE uses the vector being entered with
        case (state_n)
            IDLE:    drive_n = {(NUM_CH*5){1'b0}};
            INIT:    drive_n = {NUM_CH{INIT_PINS}};
            DRIVE:   drive_n = {NUM_CH{vec_to_pins(vec_n, MODE_BIT)}};
            default: drive_n = dut_drive;
        endcase
    end

endmodule

// File: tb/tb_chip_ff_tester.sv
// Bench for chip_ff_tester: three instances (JK default, D mode, JK with 4-bit counter)
// each wired to a behavioural flip-flop part, with fault injection on the default one.
module tb_chip_ff_tester;

    localparam int NCH = 2;
    localparam int S   = 3;
    localparam int LV  = 23;
    // edges after the one that samples Run until Done is visible (100 cycles including it)
    localparam int EXP_CYC = S + (LV + 1) * (1 + S);

    logic Clk = 1'b0;
    logic Reset, Run, DISP_RSLT;
    logic [9:0] drive_a, drive_d, drive_s;
    logic [3:0] sense_a, sense_d, sense_s;
    logic [4:0] vec_a, vec_d, vec_s;
    logic done_a, done_d, done_s, rslt_a, rslt_d, rslt_s;
    logic [7:0] cnt_a, cnt_d;
    logic [3:0] cnt_s;
    logic [1:0] mask_a, mask_d, mask_s;
`ifdef CHIP_FF_FAIL_CAPTURE_EN
    logic [4:0] ffv_a, ffv_d, ffv_s;
    logic [1:0] ffc_a, ffc_d, ffc_s;
    logic ffval_a, ffval_d, ffval_s;
`endif

    always #5 Clk = ~Clk;

    chip_ff_tester #(.NUM_CH(NCH), .MODE(0), .SETTLE_CYC(S), .LAST_VEC(LV), .CNT_W(8)) u_dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .DISP_RSLT(DISP_RSLT),
        .dut_drive(drive_a), .dut_sense(sense_a), .vec_o(vec_a), .Done(done_a),
        .RSLT(rslt_a), .fail_count(cnt_a), .fail_mask(mask_a)
`ifdef CHIP_FF_FAIL_CAPTURE_EN
        , .first_fail_vec(ffv_a), .first_fail_ch(ffc_a), .first_fail_valid(ffval_a)
`endif
    );

    chip_ff_tester #(.NUM_CH(NCH), .MODE(1), .SETTLE_CYC(S), .LAST_VEC(LV), .CNT_W(8)) u_d (
        .Clk(Clk), .Reset(Reset), .Run(Run), .DISP_RSLT(DISP_RSLT),
        .dut_drive(drive_d), .dut_sense(sense_d), .vec_o(vec_d), .Done(done_d),
        .RSLT(rslt_d), .fail_count(cnt_d), .fail_mask(mask_d)
`ifdef CHIP_FF_FAIL_CAPTURE_EN
        , .first_fail_vec(ffv_d), .first_fail_ch(ffc_d), .first_fail_valid(ffval_d)
`endif
    );

    chip_ff_tester #(.NUM_CH(NCH), .MODE(0), .SETTLE_CYC(S), .LAST_VEC(LV), .CNT_W(4)) u_sat (
        .Clk(Clk), .Reset(Reset), .Run(Run), .DISP_RSLT(DISP_RSLT),
        .dut_drive(drive_s), .dut_sense(sense_s), .vec_o(vec_s), .Done(done_s),
        .RSLT(rslt_s), .fail_count(cnt_s), .fail_mask(mask_s)
`ifdef CHIP_FF_FAIL_CAPTURE_EN
        , .first_fail_vec(ffv_s), .first_fail_ch(ffc_s), .first_fail_valid(ffval_s)
`endif
    );

    int n_chk = 0;
    int n_err = 0;
    int fault_kind = 0;  // 0 none, 1 Q@0, 2 Q@1, 3 QN@1, 4 QN@0 (on fault_ch of u_dut)
    int fault_ch = 0;
    logic k_seen = 1'b0;

    // Flip-flop behaviour from the data-sheet rules; returns {QN,Q}.
    function automatic logic [1:0] ff_next(input logic dmode, input logic clr_n, input logic pre_n,
                                           input logic clk, input logic pclk, input logic j,
                                           input logic k, input logic q);
        logic nq;
        if (!clr_n && !pre_n) return 2'b11;
        if (!clr_n) return 2'b10;
        if (!pre_n) return 2'b01;
        if (!pclk && clk) begin
            if (dmode) nq = j;
            else if (j && k) nq = 1'b1;
            else if (j) nq = !q;
            else if (k) nq = q;
            else nq = 1'b0;
        end else begin
            nq = q;
        end
        return {!nq, nq};
    endfunction

    // Whole-sweep reference: expected fail count/mask/first fail for a given fault.
    // kind 5 = QN stuck-at-1 on every channel.
    function automatic void ref_sweep(input logic dmode, input int kind, input int fch,
                                      output int cnt, output int mask, output int ffv,
                                      output int ffc);
        logic q, qn, pclk, sq, sqn;
        logic [1:0] r;
        logic [4:0] v;
        q = 1'b0; qn = 1'b1; pclk = 1'b0;
        cnt = 0; mask = 0; ffv = -1; ffc = -1;
        for (int i = 0; i <= LV; i++) begin
            v = 5'(i);
            r = ff_next(dmode, !v[4], !v[3], v[0], pclk, v[1], v[2], q);
            q = r[0]; qn = r[1]; pclk = v[0];
            for (int c = 0; c < NCH; c++) begin
                sq = q; sqn = qn;
                if (kind == 5 || c == fch) begin
                    case (kind)
                        1: sq = 1'b0;
                        2: sq = 1'b1;
                        3, 5: sqn = 1'b1;
                        4: sqn = 1'b0;
                        default: ;
                    endcase
                end
                if (sq != q || sqn != qn) begin
                    cnt++;
                    mask |= (1 << c);
                    if (ffv < 0) begin ffv = i; ffc = c; end
                end
            end
        end
    endfunction

    // Behavioural parts: pin-level flip-flops reacting to every drive change.
    logic [1:0] q_a, qn_a, pclk_a, q_d, qn_d, pclk_d, q_s, qn_s, pclk_s;
    always @(drive_a or drive_d or drive_s) begin
        for (int c = 0; c < NCH; c++) begin
            logic [1:0] r;
            r = ff_next(1'b0, drive_a[5*c+4], drive_a[5*c], drive_a[5*c+1], pclk_a[c],
                        drive_a[5*c+3], drive_a[5*c+2], q_a[c]);
            q_a[c] = r[0]; qn_a[c] = r[1]; pclk_a[c] = drive_a[5*c+1];
            r = ff_next(1'b1, drive_d[5*c+4], drive_d[5*c], drive_d[5*c+1], pclk_d[c],
                        drive_d[5*c+3], drive_d[5*c+2], q_d[c]);
            q_d[c] = r[0]; qn_d[c] = r[1]; pclk_d[c] = drive_d[5*c+1];
            r = ff_next(1'b0, drive_s[5*c+4], drive_s[5*c], drive_s[5*c+1], pclk_s[c],
                        drive_s[5*c+3], drive_s[5*c+2], q_s[c]);
            q_s[c] = r[0]; qn_s[c] = r[1]; pclk_s[c] = drive_s[5*c+1];
        end
    end

    always_comb begin
        sense_a = 4'd0; sense_d = 4'd0; sense_s = 4'd0;
        for (int c = 0; c < NCH; c++) begin
            sense_a[2*c] = q_a[c]; sense_a[2*c+1] = qn_a[c];
            if (c == fault_ch) begin
                case (fault_kind)
                    1: sense_a[2*c] = 1'b0;
                    2: sense_a[2*c] = 1'b1;
                    3: sense_a[2*c+1] = 1'b1;
                    4: sense_a[2*c+1] = 1'b0;
                    default: ;
                endcase
            end
            sense_d[2*c] = q_d[c]; sense_d[2*c+1] = qn_d[c];
            sense_s[2*c] = q_s[c]; sense_s[2*c+1] = 1'b1;
        end
    end

    always @(posedge Clk) if (drive_d[2] || drive_d[7]) k_seen <= 1'b1;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge Clk); #1;
            if (done_a) begin n = i; break; end
        end
    endtask

    task automatic run_once(output int n);
        @(negedge Clk) Run = 1'b1;
        @(posedge Clk);
        @(negedge Clk) Run = 1'b0;
        wait_done(n);
    endtask

    task automatic disp_ack();
        @(negedge Clk) DISP_RSLT = 1'b1;
        @(posedge Clk); #1;
        check("ack_done_low", done_a, 0);
        @(negedge Clk) DISP_RSLT = 1'b0;
    endtask

    typedef struct {
        int kind; int ch;
        int exp_cnt; int exp_mask; int exp_ffv; int exp_ffc;
    } case_t;

    case_t tbl[6];

    initial begin
        int n, sat_cnt, sat_mask, dv, dc;
        Reset = 1'b1; Run = 1'b0; DISP_RSLT = 1'b0;
        tbl[0].kind = 0; tbl[0].ch = 0;
        tbl[1].kind = 1; tbl[1].ch = 1;
        tbl[2].kind = 2; tbl[2].ch = 0;
        tbl[3].kind = 3; tbl[3].ch = 1;
        tbl[4].kind = int'($urandom_range(1, 4)); tbl[4].ch = int'($urandom_range(0, 1));
        tbl[5].kind = int'($urandom_range(1, 4)); tbl[5].ch = int'($urandom_range(0, 1));
        foreach (tbl[i])
            ref_sweep(1'b0, tbl[i].kind, tbl[i].ch, tbl[i].exp_cnt, tbl[i].exp_mask,
                      tbl[i].exp_ffv, tbl[i].exp_ffc);
        ref_sweep(1'b0, 5, 0, sat_cnt, sat_mask, dv, dc);
        if (sat_cnt > 15) sat_cnt = 15;

        repeat (3) @(posedge Clk);
        #1;
        check("rst_done", done_a, 0);
        check("rst_rslt", rslt_a, 0);
        check("rst_count", cnt_a, 0);
        check("rst_mask", mask_a, 0);
        check("rst_vec", vec_a, 0);
        check("rst_drive", drive_a, 0);
        @(negedge Clk) Reset = 1'b0;

        foreach (tbl[i]) begin
            @(negedge Clk);
            fault_kind = tbl[i].kind; fault_ch = tbl[i].ch;
            run_once(n);
            check("run_cycles", n, EXP_CYC);
            check("tbl_rslt", rslt_a, (tbl[i].exp_cnt == 0) ? 1 : 0);
            check("tbl_count", cnt_a, tbl[i].exp_cnt);
            check("tbl_mask", mask_a, tbl[i].exp_mask);
`ifdef CHIP_FF_FAIL_CAPTURE_EN
            check("tbl_ff_valid", ffval_a, (tbl[i].exp_cnt != 0) ? 1 : 0);
            if (tbl[i].exp_cnt != 0) begin
                check("tbl_ff_vec", ffv_a, tbl[i].exp_ffv);
                check("tbl_ff_ch", ffc_a, tbl[i].exp_ffc);
            end
`endif
            check("d_done", done_d, 1);
            check("d_rslt", rslt_d, 1);
            check("d_count", cnt_d, 0);
            check("sat_rslt", rslt_s, 0);
            check("sat_count", cnt_s, sat_cnt);
            check("sat_mask", mask_s, 3);
            disp_ack();
        end

        // Reset in SETTLE at vector 9 aborts the run.
        @(negedge Clk);
        fault_kind = 0;
        @(negedge Clk) Run = 1'b1;
        @(posedge Clk);
        @(negedge Clk) Run = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge Clk); #1;
            if (vec_a == 5'd9) begin n = 1; break; end
        end
        check("reach_vec9", n, 1);
        @(posedge Clk);
        @(negedge Clk) Reset = 1'b1;
        @(posedge Clk); #1;
        check("abort_done", done_a, 0);
        check("abort_rslt", rslt_a, 0);
        check("abort_count", cnt_a, 0);
        check("abort_mask", mask_a, 0);
        check("abort_vec", vec_a, 0);
        check("abort_drive", drive_a, 0);
        @(negedge Clk) Reset = 1'b0;
        run_once(n);
        check("rerun_cycles", n, EXP_CYC);
        check("rerun_rslt", rslt_a, 1);
        disp_ack();

        // Run held high through DONE.
        @(negedge Clk) Run = 1'b1;
        wait_done(n);
        check("held_done_seen", done_a, 1);
        repeat (5) @(posedge Clk);
        #1;
        check("held_stays_done", done_a, 1);
        @(negedge Clk) DISP_RSLT = 1'b1;
        @(posedge Clk); #1;
        check("held_ack_idle", done_a, 0);
        check("held_idle_drive", drive_a, 0);
        @(negedge Clk) DISP_RSLT = 1'b0;
        @(posedge Clk); #1;
        check("held_restart_init", drive_a, 10'b00001_00001);
        @(negedge Clk) Run = 1'b0;
        wait_done(n);
        check("held_rerun_rslt", rslt_a, 1);
        disp_ack();

        check("d_k_pins_zero", k_seen, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
